plate_edge_locate: RTL and testbench
====================================

# plate_edge_locate

Upstream stage of the character-division path: scans the binarised plate-colour video stream in raster order and finds the bounding box of the licence plate once per frame. At frame end it registers edge_left / edge_right / edge_up / edge_down, which feed the character-partition stage's edge inputs. Noise rejection uses a per-row pixel-count threshold and a minimum run of consecutive qualifying rows.

## Interface
- H_ACT, 480: active pixels per line.
- V_ACT, 272: active lines per frame.
- ROW_TH, 40: minimum plate-colour pixels for a row to qualify (must be ≥2).
- MIN_ROWS, 8: minimum consecutive qualifying rows for a plate.

- clk  in  1  pixel clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i_x  in  12  pixel X position, 0..H_ACT-1.
- i_y  in  12  pixel Y position, 0..V_ACT-1.
- de  in  1  pixel valid; i_x, i_y and bin_pix are ignored when low.
- bin_pix  in  1  1 = pixel matches plate colour.
- edge_left  out  12  leftmost plate X.
- edge_right  out  12  rightmost plate X.
- edge_up  out  12  top plate row.
- edge_down  out  12  bottom plate row.
- plate_valid  out  1  last completed frame contained a plate.
- frame_done  out  1  one-cycle pulse when the frame's results are committed.

## Operation
- Pixel events:
  - row_end = de && i_x==H_ACT-1.
  - frame_end = row_end && i_y==V_ACT-1.
- Row accumulators, all include the current pixel:
  - row_cnt: count of bin_pix=1, 12 bit, saturating at 4095.
  - row_first: X of the first bin_pix=1 in the row.
  - row_last: X of the last bin_pix=1 in the row.
  - All three clear after the row_end cycle.
- Row qualifies at row_end if row_cnt (including the row_end pixel) ≥ ROW_TH.
- Run registers: run_up, run_down, run_left (min), run_right (max), run_cnt (12 bit, saturating).
- FSM, evaluated only on row_end:
  - SEARCH, qualifying row: → IN_RUN; run_up=run_down=i_y, run_left=row_first, run_right=row_last, run_cnt=1.
  - SEARCH, non-qualifying row: stay in SEARCH.
  - IN_RUN, qualifying row: run_cnt+1; run_down=i_y; run_left=min(run_left,row_first); run_right=max(run_right,row_last).
  - IN_RUN, non-qualifying row: → LOCKED if run_cnt ≥ MIN_ROWS, else → SEARCH (run discarded).
  - LOCKED: all further rows ignored; the first valid run in a frame wins.
- frame_end:
  - The last row is first applied per the IN_RUN rules.
  - Plate found if the state is LOCKED, or if it is IN_RUN with updated run_cnt ≥ MIN_ROWS.
  - Plate found: edges ← run registers, plate_valid ← 1.
  - No plate found: edges hold their previous values, plate_valid ← 0.
  - In both cases frame_done pulses and the FSM → SEARCH.
- Reset values: all edges 0, plate_valid 0, frame_done 0, FSM SEARCH, all accumulators 0.
- Reset mid-frame clears everything immediately. The first frame_done after reset may reflect a partial frame; it is committed normally.

## Timing
- Row qualification and FSM update are registered on the row_end clock edge.
- Outputs and frame_done are valid the cycle after the frame_end pixel (latency 1).
- Edges stay stable for the whole following frame; downstream may sample them at any point during that frame.
- de gaps mid-row are allowed; only de-high pixels count.
- Simultaneous row_end and frame_end are a single event: the last row is evaluated before the commit.

## Test plan
- Reset: assert rst_n=0 mid-frame → all outputs 0 asynchronously; after release, no frame_done until the next pixel (479,271).
- Clean plate: bin_pix=1 for x 100..299, y 80..139; ROW_TH=40, MIN_ROWS=8 → one cycle after pixel (479,271): edges 100/299/80/139, plate_valid=1, frame_done one cycle wide.
- Noise run: rows 20..24 fully 1 (5 rows), then plate x 50..249, y 150..199 → edges 50/249/150/199, plate_valid=1.
- Empty frame following the clean-plate frame → plate_valid=0, edges still 100/299/80/139, frame_done pulses.
- Bottom run: x 10..409, y 260..271 → committed at frame_end without a terminating row: up=260, down=271, left=10, right=409, plate_valid=1.
- Threshold edge: plate y 100..119 with row 110 holding exactly 39 pixels → first run 100..109 (10 rows) locked; edges up=100, down=109. Repeat with 40 pixels in row 110 → up=100, down=119.

Source files
------------

// File: rtl/plate_edge_locate.sv
// rtl/plate_edge_locate.sv - per-frame licence plate bounding box from a binarised raster stream
module plate_edge_locate #(
  parameter int H_ACT    = 480,
  parameter int V_ACT    = 272,
  parameter int ROW_TH   = 40,
  parameter int MIN_ROWS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] i_x,
  input  logic [11:0] i_y,
  input  logic        de,
  input  logic        bin_pix,
  output logic [11:0] edge_left,
  output logic [11:0] edge_right,
  output logic [11:0] edge_up,
  output logic [11:0] edge_down,
  output logic        plate_valid,
  output logic        frame_done
);

  typedef enum logic [1:0] {SEARCH, IN_RUN, LOCKED} state_t;

  state_t      state, n_state;
  logic [11:0] row_cnt, row_first, row_last;
  logic [11:0] cur_cnt, cur_first, cur_last;
  logic [11:0] run_up, run_down, run_left, run_right, run_cnt;
  logic [11:0] n_up, n_down, n_left, n_right, n_cnt;
  logic        pix, row_end, frame_end, qual, found;

  assign pix       = de & bin_pix;
  assign row_end   = de && (i_x == 12'(H_ACT - 1));
  assign frame_end = row_end && (i_y == 12'(V_ACT - 1));

  // Row statistics including the current pixel; a zero count means no first X seen yet
  always_comb begin
    cur_cnt   = (pix && row_cnt != 12'hFFF) ? row_cnt + 12'd1 : row_cnt;
    cur_first = (pix && row_cnt == 12'd0) ? i_x : row_first;
    cur_last  = pix ? i_x : row_last;
    qual      = cur_cnt >= 12'(ROW_TH);
  end

  // Next run state as if the current row ended now; also used for the frame-end commit
  always_comb begin
    n_state = state;
    n_up    = run_up;
    n_down  = run_down;
    n_left  = run_left;
    n_right = run_right;
    n_cnt   = run_cnt;
    case (state)
      SEARCH: begin
        if (qual) begin
          n_state = IN_RUN;
          n_up    = i_y;
          n_down  = i_y;
          n_left  = cur_first;
          n_right = cur_last;
          n_cnt   = 12'd1;
        end
      end
      IN_RUN: begin
        if (qual) begin
          n_cnt   = (run_cnt == 12'hFFF) ? run_cnt : run_cnt + 12'd1;
          n_down  = i_y;
          n_left  = (cur_first < run_left) ? cur_first : run_left;
          n_right = (cur_last > run_right) ? cur_last : run_right;
        end else begin
          n_state = (run_cnt >= 12'(MIN_ROWS)) ? LOCKED : SEARCH;
        end
      end
      default: n_state = state;
    endcase
    found = (n_state == LOCKED) || (n_state == IN_RUN && n_cnt >= 12'(MIN_ROWS));
  end

  // Row accumulators: follow de-high pixels, clear after the row's last pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt   <= 12'd0;
      row_first <= 12'd0;
      row_last  <= 12'd0;
    end else if (row_end) begin
      row_cnt   <= 12'd0;
      row_first <= 12'd0;
      row_last  <= 12'd0;
    end else if (de) begin
      row_cnt   <= cur_cnt;
      row_first <= cur_first;
      row_last  <= cur_last;
    end
  end

  // Run tracking FSM, stepped once per row; a new frame always starts searching
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEARCH;
      run_up    <= 12'd0;
      run_down  <= 12'd0;
      run_left  <= 12'd0;
      run_right <= 12'd0;
      run_cnt   <= 12'd0;
    end else if (frame_end) begin
      state     <= SEARCH;
      run_cnt   <= 12'd0;
    end else if (row_end) begin
      state     <= n_state;
      run_up    <= n_up;
      run_down  <= n_down;
      run_left  <= n_left;
      run_right <= n_right;
      run_cnt   <= n_cnt;
    end
  end

  // Frame commit: edges update only when a plate was found, otherwise they hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_left   <= 12'd0;
      edge_right  <= 12'd0;
      edge_up     <= 12'd0;
      edge_down   <= 12'd0;
      plate_valid <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (frame_end) begin
        plate_valid <= found;
        if (found) begin
          edge_left  <= n_left;
          edge_right <= n_right;
          edge_up    <= n_up;
          edge_down  <= n_down;
        end
      end
    end
  end

endmodule

// File: tb/tb_plate_edge_locate.sv
// tb/tb_plate_edge_locate.sv - randomized and directed bench for plate_edge_locate
module tb_plate_edge_locate;
  localparam int H  = 480;
  localparam int V  = 272;
  localparam int TH = 40;
  localparam int MR = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] i_x, i_y;
  logic        de, bin_pix;
  logic [11:0] edge_left, edge_right, edge_up, edge_down;
  logic        plate_valid, frame_done;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  int exp_pulses = 0;
  int exp_l = 0, exp_r = 0, exp_u = 0, exp_d = 0, exp_v = 0;
  bit img [V][H];

  plate_edge_locate #(.H_ACT(H), .V_ACT(V), .ROW_TH(TH), .MIN_ROWS(MR)) dut (
    .clk(clk), .rst_n(rst_n), .i_x(i_x), .i_y(i_y), .de(de), .bin_pix(bin_pix),
    .edge_left(edge_left), .edge_right(edge_right), .edge_up(edge_up),
    .edge_down(edge_down), .plate_valid(plate_valid), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n === 1'b1 && frame_done === 1'b1) pulses++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_img();
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) img[y][x] = 1'b0;
  endtask

  task automatic rect(input int x0, input int x1, input int y0, input int y1);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) img[y][x] = 1'b1;
  endtask

  // Keep only the first k plate pixels of row y inside [x0,x1]
  task automatic thin_row(input int y, input int x0, input int x1, input int k);
    for (int x = x0; x <= x1; x++) img[y][x] = (x - x0 < k);
  endtask

  // Reference: first run of >= MR consecutive qualifying rows among rows y_start..V-1
  task automatic model(input int y_start);
    int rs, l, r, cnt, f, la;
    bit found;
    rs = -1; l = 0; r = 0; found = 0;
    for (int y = y_start; y < V && !found; y++) begin
      cnt = 0; f = -1; la = -1;
      for (int x = 0; x < H; x++) if (img[y][x]) begin
        cnt++;
        if (f < 0) f = x;
        la = x;
      end
      if (cnt >= TH) begin
        if (rs < 0) begin rs = y; l = f; r = la; end
        else begin l = (f < l) ? f : l; r = (la > r) ? la : r; end
        if (y == V - 1 && y - rs + 1 >= MR) begin
          found = 1; exp_u = rs; exp_d = y; exp_l = l; exp_r = r;
        end
      end else begin
        if (rs >= 0 && y - rs >= MR) begin
          found = 1; exp_u = rs; exp_d = y - 1; exp_l = l; exp_r = r;
        end
        rs = -1;
      end
    end
    exp_v = found;
  endtask

  task automatic send(input int x, input int y, input bit b);
    @(negedge clk);
    de = 1'b1; i_x = 12'(x); i_y = 12'(y); bin_pix = b;
  endtask

  // de-low cycle carrying a frame-end position with a set pixel; must be ignored
  task automatic gap();
    @(negedge clk);
    de = 1'b0; i_x = 12'(H - 1); i_y = 12'(V - 1); bin_pix = 1'b1;
  endtask

  task automatic run_frame(input int y_start, input string tag);
    model(y_start);
    for (int y = y_start; y < V; y++)
      for (int x = 0; x < H; x++)
        if (img[y][x] || x == H - 1) begin
          if ($urandom_range(0, 15) == 0) gap();
          send(x, y, img[y][x]);
        end
    @(negedge clk);
    de = 1'b0; bin_pix = 1'b0; i_x = 12'd0; i_y = 12'd0;
    exp_pulses++;
    chk({tag, ".done"}, frame_done, 1);
    chk({tag, ".valid"}, plate_valid, exp_v);
    chk({tag, ".left"}, edge_left, exp_l);
    chk({tag, ".right"}, edge_right, exp_r);
    chk({tag, ".up"}, edge_up, exp_u);
    chk({tag, ".down"}, edge_down, exp_d);
    @(negedge clk);
    chk({tag, ".done_width"}, frame_done, 0);
    chk({tag, ".pulses"}, pulses, exp_pulses);
  endtask

  initial begin
    int x0, w, y0, h;
    rst_n = 1'b0; de = 1'b0; bin_pix = 1'b0; i_x = 12'd0; i_y = 12'd0;
    repeat (3) @(negedge clk);
    chk("rst.valid", plate_valid, 0);
    chk("rst.done", frame_done, 0);
    chk("rst.edges", {edge_left[7:0], edge_right[7:0], edge_up[7:0], edge_down[7:0]}, 0);
    rst_n = 1'b1;

    clear_img(); rect(100, 299, 80, 139);
    run_frame(0, "clean");
    chk("clean.const", {edge_left, edge_right}, {12'd100, 12'd299, 8'd0} >> 8);
    chk("clean.const_ud", {edge_up, edge_down}, {12'd80, 12'd139, 8'd0} >> 8);

    clear_img();
    run_frame(0, "empty");
    chk("empty.hold", {edge_left, edge_up}, {12'd100, 12'd80, 8'd0} >> 8);

    clear_img(); rect(0, H - 1, 20, 24); rect(50, 249, 150, 199);
    run_frame(0, "noise");

    clear_img(); rect(10, 409, 260, 271);
    run_frame(0, "bottom");
    chk("bottom.const", {edge_up, edge_down}, {12'd260, 12'd271, 8'd0} >> 8);

    clear_img(); rect(100, 199, 100, 119); thin_row(110, 100, 199, 39);
    run_frame(0, "th39");
    chk("th39.down", edge_down, 109);
    clear_img(); rect(100, 199, 100, 119); thin_row(110, 100, 199, 40);
    run_frame(0, "th40");
    chk("th40.down", edge_down, 119);

    // asynchronous reset in the middle of a frame
    clear_img(); rect(100, 299, 30, 60);
    for (int y = 0; y < 40; y++)
      for (int x = 0; x < H; x++)
        if (img[y][x] || x == H - 1) send(x, y, img[y][x]);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("amid.valid", plate_valid, 0);
    chk("amid.done", frame_done, 0);
    chk("amid.edges", {edge_left[7:0], edge_right[7:0], edge_up[7:0], edge_down[7:0]}, 0);
    @(negedge clk);
    de = 1'b0; rst_n = 1'b1;
    exp_l = 0; exp_r = 0; exp_u = 0; exp_d = 0; exp_v = 0;
    clear_img(); rect(200, 280, 250, 253);
    run_frame(240, "after_rst");

    for (int k = 0; k < 6; k++) begin
      clear_img();
      x0 = $urandom_range(0, 350); w = $urandom_range(40, 120);
      y0 = $urandom_range(0, 235); h = $urandom_range(2, 30);
      rect(x0, x0 + w - 1, y0, y0 + h - 1);
      if (h > 4) thin_row(y0 + $urandom_range(1, h - 2), x0, x0 + w - 1, $urandom_range(TH - 2, TH + 1));
      if ($urandom_range(0, 1) == 1) rect($urandom_range(0, 400), $urandom_range(400, 479),
                                          $urandom_range(0, 260), $urandom_range(260, 271));
      run_frame(0, $sformatf("rnd%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
